// File: rtl/vsr_line_fetcher.sv
// vsr_line_fetcher: display-file fetch stage.
// Holds the Video Start Register pointer. On each line start it reads
// LINE_WORDS 16-bit words sequentially from memory and queues them in a
// show-ahead FIFO for the pixel decoder. It stalls the bus while the FIFO
// is full, and it flags lines that restart while busy (overrun) and pops
// from an empty FIFO (underflow).
module vsr_line_fetcher #(
  parameter int LINE_WORDS = 192,  // 1..1023
  parameter int FIFO_DEPTH = 16    // power of two, >= 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_reload_vsr,
  input  logic [21:0] i_vsr,
  input  logic        i_line_start,
  output logic [21:0] o_address,
  output logic        o_as,
  input  logic [15:0] i_din,
  input  logic        i_bus_ack,
  output logic [15:0] o_pixel_data,
  output logic        o_pixel_valid,
  input  logic        i_pixel_pop,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [9:0]    WORDS_C = 10'(LINE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PAUSE,
    S_RESTART
  } state_t;

  // Registered state
  state_t        r_state;
  logic [21:0]   r_ptr;
  logic [21:0]   r_address;
  logic          r_as;
  logic          r_busy;
  logic [9:0]    r_words_left;
  logic          r_overrun;
  logic          r_underflow;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_mem [FIFO_DEPTH];

  // Next-state values
  state_t        w_state_nxt;
  logic [21:0]   w_ptr_nxt;
  logic [21:0]   w_address_nxt;
  logic          w_as_nxt;
  logic          w_busy_nxt;
  logic [9:0]    w_words_left_nxt;
  logic          w_overrun_nxt;
  logic          w_underflow_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_flush;
  logic          w_push;
  logic          w_pop;
  logic [21:0]   w_vsr_word;
  logic [CW-1:0] w_count_after_push;

  // Next-state, bus control and FIFO bookkeeping
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_address_nxt    = r_address;
    w_as_nxt         = r_as;
    w_busy_nxt       = r_busy;
    w_words_left_nxt = r_words_left;
    w_overrun_nxt    = r_overrun;
    w_underflow_nxt  = r_underflow;
    w_flush          = 1'b0;
    w_push           = 1'b0;
    w_pop            = i_pixel_pop && (r_count != '0);
    w_vsr_word       = i_vsr & ~22'h1;
    // Occupancy the FIFO would have if a word were pushed this cycle.
    w_count_after_push = r_count + CW'(1) - CW'(w_pop);

    if (i_pixel_pop && (r_count == '0)) begin
      w_underflow_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_line_start) begin
          w_flush          = 1'b1;
          w_address_nxt    = i_reload_vsr ? w_vsr_word : r_ptr;
          w_words_left_nxt = WORDS_C;
          w_as_nxt         = 1'b1;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = S_FETCH;
        end
      end

      S_FETCH: begin
        if (i_line_start) begin
          // Late line start: drop queued data and any ack this cycle, then
          // resume from the first word that was not yet accepted.
          w_overrun_nxt = 1'b1;
          w_flush       = 1'b1;
          w_as_nxt      = 1'b0;
          w_ptr_nxt     = r_address;
          w_state_nxt   = S_RESTART;
        end else if (r_as && i_bus_ack) begin
          w_push           = 1'b1;
          w_address_nxt    = r_address + 22'd2;
          w_words_left_nxt = r_words_left - 10'd1;
          if (r_words_left == 10'd1) begin
            w_as_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = r_address + 22'd2;
            w_state_nxt = S_IDLE;
          end else if (w_count_after_push == DEPTH_C) begin
            w_as_nxt    = 1'b0;
            w_state_nxt = S_PAUSE;
          end
        end
      end

      S_PAUSE: begin
        if (i_line_start) begin
          w_overrun_nxt = 1'b1;
          w_flush       = 1'b1;
          w_ptr_nxt     = r_address;
          w_state_nxt   = S_RESTART;
        end else if (r_count < DEPTH_C) begin
          w_as_nxt    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      S_RESTART: begin
        if (i_line_start) begin
          w_overrun_nxt = 1'b1;
          w_flush       = 1'b1;
        end else begin
          w_words_left_nxt = WORDS_C;
          w_as_nxt         = 1'b1;
          w_state_nxt      = S_FETCH;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // A reload only retargets the next line; the fetch in flight runs on
    // r_address, so the new pointer wins over any automatic advance.
    if (i_reload_vsr) begin
      w_ptr_nxt = w_vsr_word;
    end

    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      w_wr_ptr_nxt = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      w_rd_ptr_nxt = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
      w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // State register with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_address    <= '0;
      r_as         <= 1'b0;
      r_busy       <= 1'b0;
      r_words_left <= '0;
      r_overrun    <= 1'b0;
      r_underflow  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_address    <= w_address_nxt;
      r_as         <= w_as_nxt;
      r_busy       <= w_busy_nxt;
      r_words_left <= w_words_left_nxt;
      r_overrun    <= w_overrun_nxt;
      r_underflow  <= w_underflow_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
    end
  end

  // FIFO storage write port
  // NOTE: the storage array is deliberately not reset; r_count gates
  // o_pixel_valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_address     = r_address;
  assign o_as          = r_as;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_underflow   = r_underflow;
  assign o_pixel_valid = (r_count != '0);
  assign o_pixel_data  = r_mem[r_rd_ptr];

endmodule
